// File: rtl/mem_multicycle_responder_pkg.sv
// rtl/mem_multicycle_responder_pkg.sv - shared constants for the cache-fill memory responder
// The fill controller imports this too, so burst length and latency agree on both sides.
package mem_multicycle_responder_pkg;

  localparam int ADDR_WIDTH_DEF    = 16;
  localparam int DATA_WIDTH_DEF    = 16;
  localparam int DEPTH_WORDS_DEF   = 32768;
  localparam int LATENCY_DEF       = 4;
  localparam int LATENCY_MAX       = 8;
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORDS_PER_BLOCK   = 8;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_kind_e;

endpackage

// File: rtl/mem_multicycle_responder_if.sv
// rtl/mem_multicycle_responder_if.sv - request/response bus between a fill controller and the responder
interface mem_multicycle_responder_if
  import mem_multicycle_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                  enable;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  rd_pending;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, rd_pending
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, rd_pending
  );

endinterface

// File: rtl/mem_delay_stage.sv
// rtl/mem_delay_stage.sv - one valid/data register stage of the read-return pipeline
module mem_delay_stage #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

endmodule

// File: rtl/mem_multicycle_responder.sv
// rtl/mem_multicycle_responder.sv - word memory returning reads a fixed LATENCY cycles after issue
// Read data is captured at issue, so a later write to the same word never affects an in-flight read.
module mem_multicycle_responder
  import mem_multicycle_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int LATENCY     = LATENCY_DEF
) (
  input logic                       clk,
  input logic                       rst_n,
  mem_multicycle_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [IDX_W-1:0]      idx;
  req_kind_e             kind;
  logic                  wr_issue;
  logic                  rd_issue;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_addr;

  // Byte address to word index; upper bits beyond the array wrap silently.
  assign idx         = bus.addr[IDX_W:1];
  assign unused_addr = ^bus.addr;
  assign kind        = req_kind_e'(bus.wr);
  assign wr_issue    = bus.enable && (kind == REQ_WRITE);
  assign rd_issue    = bus.enable && (kind == REQ_READ);
  assign rd_word     = mem[idx];

  always_ff @(posedge clk) begin
    if (wr_issue) begin
      mem[idx] <= bus.data_in;
    end
  end

  logic [LATENCY:0]      stage_valid;
  logic [DATA_WIDTH-1:0] stage_data [LATENCY+1];

  assign stage_valid[0] = rd_issue;
  assign stage_data[0]  = rd_issue ? rd_word : '0;

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    mem_delay_stage #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (stage_valid[k]),
      .in_data  (stage_data[k]),
      .out_valid(stage_valid[k+1]),
      .out_data (stage_data[k+1])
    );
  end

  assign bus.data_valid = stage_valid[LATENCY];
  assign bus.data_out   = stage_valid[LATENCY] ? stage_data[LATENCY] : '0;
  assign bus.rd_pending = |stage_valid[LATENCY:1];

endmodule

// File: tb/tb_mem_multicycle_responder.sv
// tb/tb_mem_multicycle_responder.sv - self-checking bench for mem_multicycle_responder
module tb_mem_multicycle_responder;

  localparam int NI  = 3;
  localparam int CYC = 2000;
  localparam int LAT [NI] = '{4, 1, 8};
  localparam int DEP [NI] = '{32768, 16, 32768};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic w = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] din = '0;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_multicycle_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) b0 ();
  mem_multicycle_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) b1 ();
  mem_multicycle_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) b8 ();

  assign b0.enable = en; assign b0.wr = w; assign b0.addr = a; assign b0.data_in = din;
  assign b1.enable = en; assign b1.wr = w; assign b1.addr = a; assign b1.data_in = din;
  assign b8.enable = en; assign b8.wr = w; assign b8.addr = a; assign b8.data_in = din;

  mem_multicycle_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH_WORDS(32768), .LATENCY(4))
    u_l4 (.clk(clk), .rst_n(rst_n), .bus(b0));
  mem_multicycle_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH_WORDS(16), .LATENCY(1))
    u_l1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mem_multicycle_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH_WORDS(32768), .LATENCY(8))
    u_l8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  logic        ov [NI];
  logic [15:0] od [NI];
  logic        op [NI];
  assign ov[0] = b0.data_valid; assign od[0] = b0.data_out; assign op[0] = b0.rd_pending;
  assign ov[1] = b1.data_valid; assign od[1] = b1.data_out; assign op[1] = b1.rd_pending;
  assign ov[2] = b8.data_valid; assign od[2] = b8.data_out; assign op[2] = b8.rd_pending;

  // Model: a word array per instance plus a schedule of which cycle each read must appear in.
  int          e = 0;
  logic [15:0] mm    [NI][32768];
  logic        mk    [NI][32768];
  logic        exp_v [NI][CYC];
  logic [15:0] exp_d [NI][CYC];
  logic        exp_k [NI][CYC];

  initial begin
    for (int i = 0; i < NI; i++) begin
      for (int j = 0; j < 32768; j++) begin mm[i][j] = '0; mk[i][j] = 1'b0; end
      for (int j = 0; j < CYC; j++) begin exp_v[i][j] = 1'b0; exp_d[i][j] = '0; exp_k[i][j] = 1'b0; end
    end
  end

  always @(posedge clk) begin
    e = e + 1;
    if (rst_n && en) begin
      for (int i = 0; i < NI; i++) begin
        int ix;
        ix = (int'(a) / 2) % DEP[i];
        if (w) begin
          mm[i][ix] = din;
          mk[i][ix] = 1'b1;
        end else begin
          exp_v[i][e + LAT[i] - 1] = 1'b1;
          exp_d[i][e + LAT[i] - 1] = mm[i][ix];
          exp_k[i][e + LAT[i] - 1] = mk[i][ix];
        end
      end
    end
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < NI; i++)
      for (int j = 0; j < CYC; j++) exp_v[i][j] = 1'b0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic pend;
      logic d_ok;
      pend = 1'b0;
      for (int k = e; k <= e + 8; k++) pend = pend | exp_v[i][k];
      d_ok = exp_v[i][e] ? (!exp_k[i][e] || od[i] === exp_d[i][e]) : (od[i] === 16'h0000);
      n_tests++;
      if (ov[i] !== exp_v[i][e] || op[i] !== pend || !d_ok) begin
        n_fail++;
        $display("FAIL model inst=%0d cyc=%0d got v=%b p=%b d=%h want v=%b p=%b d=%h",
                 i, e, ov[i], op[i], od[i], exp_v[i][e], pend, exp_d[i][e]);
      end
    end
  end

  task automatic req(input logic ren, input logic rw, input logic [15:0] ra, input logic [15:0] rd);
    en = ren; w = rw; a = ra; din = rd;
    @(negedge clk);
  endtask

  task automatic idle();
    req(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic lit(input string nm, input logic v, input logic [15:0] d, input logic [15:0] x);
    n_tests++;
    if (v !== 1'b1 || d !== x) begin
      n_fail++;
      $display("FAIL %s got v=%b d=%h want v=1 d=%h", nm, v, d, x);
    end
  endtask

  task automatic lit_bit(input string nm, input logic v, input logic x);
    n_tests++;
    if (v !== x) begin
      n_fail++;
      $display("FAIL %s got %b want %b", nm, v, x);
    end
  endtask

  // Read one word and pin its arrival cycle and value on each latency variant (mask bit per instance).
  task automatic lit_read(input string nm, input logic [15:0] ra, input logic [15:0] x4,
                          input logic [15:0] x1, input logic [15:0] x8, input logic [2:0] m);
    req(1'b1, 1'b0, ra, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      if (k == 0 && m[1]) lit({nm, "_l1"}, ov[1], od[1], x1);
      if (k == 3 && m[0]) lit({nm, "_l4"}, ov[0], od[0], x4);
      if (k == 7 && m[2]) lit({nm, "_l8"}, ov[2], od[2], x8);
      idle();
    end
  endtask

  initial begin
    #1;
    for (int i = 0; i < NI; i++) begin
      lit_bit("reset_valid", ov[i], 1'b0);
      lit_bit("reset_pending", op[i], 1'b0);
      lit_bit("reset_dout_zero", od[i] == 16'h0000, 1'b1);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single read.
    req(1'b1, 1'b1, 16'h0040, 16'hBEEF);
    lit_read("single", 16'h0040, 16'hBEEF, 16'hBEEF, 16'hBEEF, 3'b111);

    // Block burst: eight back-to-back reads return as eight consecutive words.
    for (int i = 0; i < 8; i++) req(1'b1, 1'b1, 16'h1230 + 16'(2 * i), 16'(i + 1));
    for (int k = 0; k < 12; k++) begin
      if (k < 8) req(1'b1, 1'b0, 16'h1230 + 16'(2 * k), 16'h0000);
      else idle();
      if (k >= 3 && k <= 10) lit("burst", ov[0], od[0], 16'(k - 2));
      if (k == 10) lit_bit("burst_pend_last", op[0], 1'b1);
      if (k == 11) lit_bit("burst_pend_drop", op[0], 1'b0);
    end
    repeat (8) idle();

    // Read-after-write and write-after-read ordering.
    req(1'b1, 1'b1, 16'h0100, 16'h1111);
    lit_read("raw", 16'h0100, 16'h1111, 16'h1111, 16'h1111, 3'b111);
    req(1'b1, 1'b0, 16'h0100, 16'h0000);
    req(1'b1, 1'b1, 16'h0100, 16'h2222);
    idle(); idle();
    lit("war_old", ov[0], od[0], 16'h1111);
    repeat (6) idle();
    lit_read("war_new", 16'h0100, 16'h2222, 16'h2222, 16'h2222, 3'b111);

    // Gaps between reads mirror onto data_valid.
    req(1'b1, 1'b0, 16'h0040, 16'h0000);
    idle();
    req(1'b1, 1'b0, 16'h0100, 16'h0000);
    idle(); idle();
    req(1'b1, 1'b0, 16'h0040, 16'h0000);
    repeat (10) idle();

    // Address aliasing: bit 0 ignored, and depth wrap on the small instance.
    req(1'b1, 1'b1, 16'h0205, 16'hA5A5);
    lit_read("alias_b0", 16'h0204, 16'hA5A5, 16'hA5A5, 16'hA5A5, 3'b111);
    req(1'b1, 1'b1, 16'h0000, 16'h5A5A);
    lit_read("alias_depth", 16'h0020, 16'h0000, 16'h5A5A, 16'h0000, 3'b010);

    // Reset mid-burst drops in-flight reads but keeps the array.
    for (int i = 0; i < 4; i++) req(1'b1, 1'b0, 16'h1230 + 16'(2 * i), 16'h0000);
    idle();
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      lit_bit("midreset_valid", ov[i], 1'b0);
      lit_bit("midreset_pending", op[i], 1'b0);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    repeat (12) idle();
    lit_read("retain", 16'h0040, 16'hBEEF, 16'h5A5A, 16'hBEEF, 3'b111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
